core_mem_responder: RTL

//  Responder end of mem_rwport: owns the 256x16 main memory and serves LSU load/store

---
 rtl/core_pkg.sv | 11 +
 rtl/mem_rwport.sv | 13 +
 rtl/core_mem_array.sv | 29 ++
 rtl/core_mem_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core memory responder slice.
package core_pkg;

    typedef logic [7:0]  addr_t;
    typedef logic [15:0] word_t;

    localparam addr_t IO_ADDR = 8'hFF;

    typedef enum logic {IDLE, CLEAR} mem_state_e;

endpackage

// File: rtl/mem_rwport.sv
// Core-side memory request/response bundle between core_lsu and core_mem_responder.
interface mem_rwport;

    logic            val;
    logic            wen;
    core_pkg::addr_t addr;
    core_pkg::word_t wdata;
    core_pkg::word_t rdata;

    modport master (output val, output wen, output addr, output wdata, input rdata);
    modport slave  (input val, input wen, input addr, input wdata, output rdata);

endinterface

// File: rtl/core_mem_array.sv
// Single-port synchronous RAM: one write or one read per cycle, registered read data.
module core_mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [7:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage and read register are deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_mem_responder.sv
// Main-memory responder: arbitrates clear sweep, core port and front-panel port onto one RAM.
module core_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned WIDTH   = 16,
    parameter logic [7:0]  IO_ADDR = core_pkg::IO_ADDR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_rwport.slave         mem_intf,
    input  logic             pnl_val_i,
    input  logic             pnl_wen_i,
    input  logic [7:0]       pnl_addr_i,
    input  logic [WIDTH-1:0] pnl_wdata_i,
    output logic             pnl_rdy_o,
    output logic [WIDTH-1:0] pnl_rdata_o,
    output logic             pnl_rvalid_o,
    input  logic             clr_i,
    output logic             busy_o
);

    import core_pkg::*;

    localparam addr_t LastAddr = addr_t'(DEPTH - 1);

    mem_state_e       state_q;
    addr_t            cnt_q;
    logic             busy_q;

    logic             core_val;
    logic             core_io;
    logic             pnl_io;

    logic             arr_we;
    logic             arr_re;
    addr_t            arr_addr;
    logic [WIDTH-1:0] arr_wdata;
    logic [WIDTH-1:0] arr_rdata;

    // *_arr_q: the output this cycle comes straight from the RAM read register;
    // otherwise the held copy is shown.
    logic             core_arr_q;
    logic [WIDTH-1:0] core_hold_q;
    logic             pnl_arr_q;
    logic [WIDTH-1:0] pnl_hold_q;
    logic             pnl_rvalid_q;

    assign core_val  = mem_intf.val;
    assign core_io   = (mem_intf.addr == IO_ADDR);
    assign pnl_io    = (pnl_addr_i == IO_ADDR);
    assign pnl_rdy_o = pnl_val_i && !core_val && (state_q == IDLE);

    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = mem_intf.addr;
        arr_wdata = mem_intf.wdata;
        if (state_q == CLEAR) begin
            arr_we    = (cnt_q != IO_ADDR);
            arr_addr  = cnt_q;
            arr_wdata = '0;
        end else if (core_val) begin
            arr_we = mem_intf.wen && !core_io;
            arr_re = !mem_intf.wen && !core_io;
        end else if (pnl_rdy_o) begin
            arr_addr  = pnl_addr_i;
            arr_wdata = pnl_wdata_i;
            arr_we    = pnl_wen_i && !pnl_io;
            arr_re    = !pnl_wen_i && !pnl_io;
        end
    end

    core_mem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_i) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == LastAddr) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_arr_q   <= 1'b0;
            core_hold_q  <= '0;
            pnl_arr_q    <= 1'b0;
            pnl_hold_q   <= '0;
            pnl_rvalid_q <= 1'b0;
        end else begin
            if (core_arr_q) begin
                core_hold_q <= arr_rdata;
            end
            if (pnl_arr_q) begin
                pnl_hold_q <= arr_rdata;
            end
            core_arr_q   <= 1'b0;
            pnl_arr_q    <= 1'b0;
            pnl_rvalid_q <= 1'b0;
            if (core_val && !mem_intf.wen) begin
                if (state_q == IDLE && !core_io) begin
                    core_arr_q <= 1'b1;
                end else begin
                    core_hold_q <= '0;
                end
            end
            if (pnl_rdy_o && !pnl_wen_i) begin
                pnl_rvalid_q <= 1'b1;
                if (!pnl_io) begin
                    pnl_arr_q <= 1'b1;
                end else begin
                    pnl_hold_q <= '0;
                end
            end
        end
    end

    assign mem_intf.rdata = core_arr_q ? arr_rdata : core_hold_q;
    assign pnl_rdata_o    = pnl_arr_q ? arr_rdata : pnl_hold_q;
    assign pnl_rvalid_o   = pnl_rvalid_q;
    assign busy_o         = busy_q;

endmodule
